// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl
// Player-movement controller for the VGA maze. Synchronizes (and optionally
// debounces) the five push-buttons, queues one pending move and one pending
// control press, and during the vsync falling edge checks the target cell
// against the shared maze ROM before committing the move.
//
// Configuration macro: DEBOUNCE_EN -- when defined, each synchronized button
// level must differ from the accepted level for DEBOUNCE_CYCLES consecutive
// cycles before it is accepted. When undefined the synchronized level is
// used directly.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous active-high reset
//   i_up/i_down/i_left/i_right/i_control  raw async buttons, active high
//   i_vsync      VGA vsync, active low
//   o_maze_req   controller owns the ROM port (2-cycle window per move)
//   o_maze_addr  ROM cell address y*MAZE_W + x, holds when o_maze_req=0
//   i_maze_wall  ROM wall bit, valid one cycle after the address
//   o_player_x/o_player_y  player cell
//   o_show_map   full-map enable, toggled by control
//   o_win        player is on the exit cell
//   o_leds       successful move count, saturating at 255
module maze_move_ctrl #(
  parameter int MAZE_W          = 40,
  parameter int MAZE_H          = 30,
  parameter int START_X         = 1,
  parameter int START_Y         = 1,
  parameter int EXIT_X          = 38,
  parameter int EXIT_Y          = 28,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int XW = $clog2(MAZE_W),
  localparam int YW = $clog2(MAZE_H),
  localparam int AW = $clog2(MAZE_W * MAZE_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_up,
  input  logic          i_down,
  input  logic          i_left,
  input  logic          i_right,
  input  logic          i_control,
  input  logic          i_vsync,
  output logic          o_maze_req,
  output logic [AW-1:0] o_maze_addr,
  input  logic          i_maze_wall,
  output logic [XW-1:0] o_player_x,
  output logic [YW-1:0] o_player_y,
  output logic          o_show_map,
  output logic          o_win,
  output logic [7:0]    o_leds
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CHK  = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  state_t        state, state_nxt;
  logic [4:0]    raw, sync1, sync2, level, level_d, press;
  logic          vs_r, vs_fall;
  logic          pend_mv, pend_ctrl;
  logic [1:0]    pend_dir, mv_dir;
  logic          mv_any;
  logic [XW-1:0] tgt_x, tgt_x_r;
  logic [YW-1:0] tgt_y, tgt_y_r;
  logic          off_grid;
  logic          do_restart, do_toggle, do_drop, do_start, do_commit;

  // bit order: {control, right, left, down, up}
  assign raw = {i_control, i_right, i_left, i_down, i_up};

  // two-flop synchronizer for the raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 5'd0;
      sync2 <= 5'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt [5];

  // accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 5'd0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign level = sync2;
`endif

  assign press   = level & ~level_d;
  assign mv_any  = |press[3:0];
  assign vs_fall = vs_r & ~i_vsync;

  // same-cycle move presses: up > down > left > right
  always_comb begin
    mv_dir = DIR_RIGHT;
    if (press[0])      mv_dir = DIR_UP;
    else if (press[1]) mv_dir = DIR_DOWN;
    else if (press[2]) mv_dir = DIR_LEFT;
    else               mv_dir = DIR_RIGHT;
  end

  // target cell of the pending move and its off-grid check
  always_comb begin
    tgt_x    = o_player_x;
    tgt_y    = o_player_y;
    off_grid = 1'b0;
    case (pend_dir)
      DIR_UP:    if (o_player_y == '0) off_grid = 1'b1;
                 else tgt_y = o_player_y - 1'b1;
      DIR_DOWN:  if (o_player_y == YW'(MAZE_H - 1)) off_grid = 1'b1;
                 else tgt_y = o_player_y + 1'b1;
      DIR_LEFT:  if (o_player_x == '0) off_grid = 1'b1;
                 else tgt_x = o_player_x - 1'b1;
      DIR_RIGHT: if (o_player_x == XW'(MAZE_W - 1)) off_grid = 1'b1;
                 else tgt_x = o_player_x + 1'b1;
      default:   off_grid = 1'b1;
    endcase
  end

  // FSM next-state and one-cycle action strobes
  always_comb begin
    state_nxt  = state;
    do_restart = 1'b0;
    do_toggle  = 1'b0;
    do_drop    = 1'b0;
    do_start   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      ST_IDLE: begin
        // control has priority; a move missed this frame waits for the next
        if (pend_ctrl) begin
          if (o_win) do_restart = 1'b1;
          else       do_toggle  = 1'b1;
        end else if (vs_fall && pend_mv && !o_win) begin
          if (off_grid) begin
            do_drop = 1'b1;
          end else begin
            do_start  = 1'b1;
            state_nxt = ST_RD;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD:   state_nxt = ST_CHK;
      ST_CHK: begin
        do_commit = ~i_maze_wall;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // pending move / control registers; a fresh press overwrites older moves
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mv   <= 1'b0;
      pend_dir  <= DIR_UP;
      pend_ctrl <= 1'b0;
    end else begin
      if (do_restart) begin
        pend_mv <= 1'b0;
      end else if (mv_any && !o_win) begin
        pend_mv  <= 1'b1;
        pend_dir <= mv_dir;
      end else if (do_start || do_drop) begin
        pend_mv <= 1'b0;
      end
      if (press[4])                     pend_ctrl <= 1'b1;
      else if (do_restart || do_toggle) pend_ctrl <= 1'b0;
    end
  end

  // player position, ROM port, map/win/led outputs and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r        <= 1'b1;
      level_d     <= 5'd0;
      o_player_x  <= XW'(START_X);
      o_player_y  <= YW'(START_Y);
      tgt_x_r     <= XW'(START_X);
      tgt_y_r     <= YW'(START_Y);
      o_show_map  <= 1'b0;
      o_win       <= 1'b0;
      o_leds      <= 8'd0;
      o_maze_req  <= 1'b0;
      o_maze_addr <= '0;
    end else begin
      vs_r    <= i_vsync;
      level_d <= level;
      if (do_restart) o_win <= 1'b0;
      else o_win <= (o_player_x == XW'(EXIT_X)) && (o_player_y == YW'(EXIT_Y));
      if (do_restart) begin
        o_player_x <= XW'(START_X);
        o_player_y <= YW'(START_Y);
        o_leds     <= 8'd0;
      end else if (do_commit) begin
        o_player_x <= tgt_x_r;
        o_player_y <= tgt_y_r;
        if (o_leds != 8'hFF) o_leds <= o_leds + 8'd1;
      end
      if (do_toggle) o_show_map <= ~o_show_map;
      if (do_start) begin
        tgt_x_r     <= tgt_x;
        tgt_y_r     <= tgt_y;
        o_maze_addr <= AW'(tgt_y) * AW'(MAZE_W) + AW'(tgt_x);
        o_maze_req  <= 1'b1;
      end else if (state == ST_CHK) begin
        o_maze_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed testbench for maze_move_ctrl: button presses, vsync frames and a
// behavioural maze ROM with one-cycle read latency.
module tb_maze_move_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn;          // {control, right, left, down, up}
  logic        vsync;
  logic        maze_req;
  logic [10:0] maze_addr;
  logic        maze_wall;
  logic [5:0]  px;
  logic [4:0]  py;
  logic        show_map, win;
  logic [7:0]  leds;

  logic        rom [0:1199];
  int          total = 0;
  int          bad = 0;
  int          req_cnt = 0;
  int          snap;

  logic        e1_req, e2_req, e3_req, e3_win, e4_win;
  logic [10:0] e1_addr;
  logic [5:0]  e3_x;
  logic [4:0]  e3_y;
  logic [7:0]  e3_leds;

  always #5 clk = ~clk;

  maze_move_ctrl dut (
    .clk(clk), .rst(rst),
    .i_up(btn[0]), .i_down(btn[1]), .i_left(btn[2]), .i_right(btn[3]),
    .i_control(btn[4]), .i_vsync(vsync),
    .o_maze_req(maze_req), .o_maze_addr(maze_addr), .i_maze_wall(maze_wall),
    .o_player_x(px), .o_player_y(py), .o_show_map(show_map),
    .o_win(win), .o_leds(leds)
  );

  // ROM model: data one cycle after address; count cycles with req high
  always @(posedge clk) begin
    maze_wall <= (maze_addr < 11'd1200) ? rom[maze_addr] : 1'b0;
    if (maze_req) req_cnt <= req_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] mask, input int hi, input int lo);
    btn = mask;
    repeat (hi) @(negedge clk);
    btn = 5'd0;
    repeat (lo) @(negedge clk);
  endtask

  // one vsync-low frame; captures outputs at E+1..E+4
  task automatic frame();
    vsync = 1'b0;
    @(posedge clk); #1; e1_req = maze_req; e1_addr = maze_addr;
    @(posedge clk); #1; e2_req = maze_req;
    @(posedge clk); #1; e3_req = maze_req; e3_x = px; e3_y = py;
    e3_leds = leds; e3_win = win;
    @(posedge clk); #1; e4_win = win;
    repeat (10) @(negedge clk);
    vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic move(input logic [4:0] mask);
    press(mask, 10, 5);
    frame();
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) rom[i] = 1'b0;
    rst = 1'b1; btn = 5'd0; vsync = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_x", px, 32'd1);
    check("rst_y", py, 32'd1);
    check("rst_leds", leds, 32'd0);
    check("rst_req", maze_req, 32'd0);
    check("rst_addr", maze_addr, 32'd0);
    check("rst_map", show_map, 32'd0);
    check("rst_win", win, 32'd0);

    // idle frames
    snap = req_cnt;
    repeat (3) frame();
    check("idle_req", req_cnt - snap, 32'd0);
    check("idle_x", px, 32'd1);
    check("idle_y", py, 32'd1);

    // 20 control presses
    press(5'b10000, 10, 5);
    check("map_first", show_map, 32'd1);
    for (int i = 1; i < 20; i++) press(5'b10000, 10, 5);
    check("map_end", show_map, 32'd0);
    check("map_req", req_cnt - snap, 32'd0);

    // right into open cell 42
    move(5'b01000);
    check("r_e1_req", e1_req, 32'd1);
    check("r_e1_addr", e1_addr, 32'd42);
    check("r_e2_req", e2_req, 32'd1);
    check("r_e3_req", e3_req, 32'd0);
    check("r_e3_x", e3_x, 32'd2);
    check("r_e3_leds", e3_leds, 32'd1);

    // up to (2,0), left to (1,0), up at row 0 dropped
    move(5'b00001);
    move(5'b00100);
    check("pre_drop_x", px, 32'd1);
    check("pre_drop_y", py, 32'd0);
    snap = req_cnt;
    move(5'b00001);
    check("drop_up_req", req_cnt - snap, 32'd0);
    check("drop_up_y", py, 32'd0);
    // left to (0,0), left at column 0 dropped
    move(5'b00100);
    snap = req_cnt;
    move(5'b00100);
    check("drop_left_req", req_cnt - snap, 32'd0);
    check("drop_left_x", px, 32'd0);
    check("drop_leds", leds, 32'd4);

    // back to (1,1)
    move(5'b01000);
    move(5'b00010);
    // down then right in one frame, (2,1) is a wall
    rom[42] = 1'b1;
    press(5'b00010, 10, 5);
    press(5'b01000, 10, 5);
    frame();
    check("ovr_addr", e1_addr, 32'd42);
    check("ovr_x", e3_x, 32'd1);
    check("ovr_y", e3_y, 32'd1);
    check("ovr_leds", e3_leds, 32'd6);
    snap = req_cnt;
    frame();
    check("ovr_cleared", req_cnt - snap, 32'd0);
    // up and down same cycle: up wins, (1,0) is a wall
    rom[1] = 1'b1;
    move(5'b00011);
    check("prio_addr", e1_addr, 32'd1);
    check("prio_y", py, 32'd1);
    rom[1] = 1'b0;
    rom[42] = 1'b0;

    // map on, then walk to the exit
    press(5'b10000, 10, 5);
    check("map_on", show_map, 32'd1);
    for (int i = 0; i < 27; i++) move(5'b00010);
    for (int i = 0; i < 36; i++) move(5'b01000);
    check("near_x", px, 32'd37);
    check("near_y", py, 32'd28);
    check("near_leds", leds, 32'd69);
    check("near_win", win, 32'd0);
    move(5'b01000);
    check("exit_x", e3_x, 32'd38);
    check("exit_leds", e3_leds, 32'd70);
    check("win_e3", e3_win, 32'd0);
    check("win_e4", e4_win, 32'd1);
    snap = req_cnt;
    move(5'b00100);
    check("win_lock_req", req_cnt - snap, 32'd0);
    check("win_lock_x", px, 32'd38);
    // restart
    press(5'b10000, 10, 5);
    check("rs_x", px, 32'd1);
    check("rs_y", py, 32'd1);
    check("rs_leds", leds, 32'd0);
    check("rs_win", win, 32'd0);
    check("rs_map", show_map, 32'd1);
    snap = req_cnt;
    frame();
    check("rs_no_move", req_cnt - snap, 32'd0);

    // reset during RD aborts the move
    press(5'b01000, 10, 5);
    vsync = 1'b0;
    @(posedge clk); #1;
    check("abort_rd_req", maze_req, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_req", maze_req, 32'd0);
    check("abort_x", px, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_after_x", px, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
